// File: rtl/tpram_1clk.sv
// tpram_1clk: single-clock true dual-port RAM, 2**aw words of dw bits.
// Default 2K x 8 build serves as the LZS decoder history buffer
// (literals written on port A, back-reference bytes read on port B).
// Optional feature macro: TPRAM_WRITE_THROUGH_EN
//   undefined (default): read-during-write returns the old word (read-first)
//   defined            : read-during-write returns the new word; di_a wins a collision
// rst_n clears only the read registers; memory contents are never reset.
module tpram_1clk #(
   parameter int unsigned aw = 11,
   parameter int unsigned dw = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   // port A
   input  logic          ce_a,
   input  logic          we_a,
   input  logic          oe_a,
   input  logic [aw-1:0] addr_a,
   input  logic [dw-1:0] di_a,
   output logic [dw-1:0] do_a,
   // port B
   input  logic          ce_b,
   input  logic          we_b,
   input  logic          oe_b,
   input  logic [aw-1:0] addr_b,
   input  logic [dw-1:0] di_b,
   output logic [dw-1:0] do_b
);

   localparam int unsigned depth = 1 << aw;

   logic [dw-1:0] mem [depth];
   logic [dw-1:0] rdata_a;
   logic [dw-1:0] rdata_b;
   logic [dw-1:0] rd_word_a;
   logic [dw-1:0] rd_word_b;
   logic          wr_a;
   logic          wr_b;

   // qualified write strobes: we is meaningless while ce is low
   always_comb begin
      wr_a = ce_a & we_a;
      wr_b = ce_b & we_b;
   end

   // memory write; B is applied first so a same-address write from A overrides it,
   // and nothing is written on an edge that sees rst_n low
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (wr_b) begin
            mem[addr_b] <= di_b;
         end
         if (wr_a) begin
            mem[addr_a] <= di_a;
         end
      end
   end

`ifdef TPRAM_WRITE_THROUGH_EN
   // word captured by each read port: bypass any same-address write in this cycle,
   // with port A's data taking priority over port B's
   always_comb begin
      rd_word_a = mem[addr_a];
      if (wr_b && (addr_b == addr_a)) begin
         rd_word_a = di_b;
      end
      if (wr_a) begin
         rd_word_a = di_a;
      end
      rd_word_b = mem[addr_b];
      if (wr_b) begin
         rd_word_b = di_b;
      end
      if (wr_a && (addr_a == addr_b)) begin
         rd_word_b = di_a;
      end
   end
`else
   // word captured by each read port: the stored (old) word, read-first
   always_comb begin
      rd_word_a = mem[addr_a];
      rd_word_b = mem[addr_b];
   end
`endif

   // port A read register; holds while ce_a is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_a <= '0;
      end else if (ce_a) begin
         rdata_a <= rd_word_a;
      end
   end

   // port B read register; holds while ce_b is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_b <= '0;
      end else if (ce_b) begin
         rdata_b <= rd_word_b;
      end
   end

   // output gating: zero when the output enable is low
   always_comb begin
      do_a = oe_a ? rdata_a : '0;
      do_b = oe_b ? rdata_b : '0;
   end

endmodule

// File: tb/tb_tpram_1clk.sv
// tb_tpram_1clk: directed self-checking bench for tpram_1clk (2K x 8).
// Expected values follow the TPRAM_WRITE_THROUGH_EN setting of the build.
module tb_tpram_1clk;

   localparam int unsigned aw = 11;
   localparam int unsigned dw = 8;

   logic          clk;
   logic          rst_n;
   logic          ce_a, we_a, oe_a;
   logic [aw-1:0] addr_a;
   logic [dw-1:0] di_a;
   logic [dw-1:0] do_a;
   logic          ce_b, we_b, oe_b;
   logic [aw-1:0] addr_b;
   logic [dw-1:0] di_b;
   logic [dw-1:0] do_b;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   tpram_1clk #(.aw(aw), .dw(dw)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ce_a   (ce_a),
      .we_a   (we_a),
      .oe_a   (oe_a),
      .addr_a (addr_a),
      .di_a   (di_a),
      .do_a   (do_a),
      .ce_b   (ce_b),
      .we_b   (we_b),
      .oe_b   (oe_b),
      .addr_b (addr_b),
      .di_b   (di_b),
      .do_b   (do_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [dw-1:0] obs, input logic [dw-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
      end
   endtask

   // advance one clock edge, then settle 1 time unit past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ce_a = 1'b0; we_a = 1'b0;
      ce_b = 1'b0; we_b = 1'b0;
   endtask

   task automatic write_a(input logic [aw-1:0] a, input logic [dw-1:0] d);
      ce_a = 1'b1; we_a = 1'b1; addr_a = a; di_a = d;
   endtask

   task automatic read_b(input logic [aw-1:0] a);
      ce_b = 1'b1; we_b = 1'b0; addr_b = a;
   endtask

   logic [dw-1:0] exp_rdw;
   logic [dw-1:0] exp_same;
   logic [dw-1:0] exp_col;
   logic [dw-1:0] sweep_d;

   initial begin
`ifdef TPRAM_WRITE_THROUGH_EN
      exp_rdw  = 8'h22;
      exp_same = 8'h33;
      exp_col  = 8'hAA;
`else
      exp_rdw  = 8'h11;
      exp_same = 8'h22;
      exp_col  = 8'h01;
`endif
      rst_n = 1'b0;
      oe_a = 1'b1; oe_b = 1'b1;
      addr_a = '0; addr_b = '0; di_a = '0; di_b = '0;
      idle();
      tick(); tick();
      check("reset_do_a", do_a, 8'h00);
      check("reset_do_b", do_b, 8'h00);

      // release reset away from the edge; outputs stay 0 without enabled reads
      rst_n = 1'b1;
      tick(); tick();
      check("post_reset_do_a", do_a, 8'h00);
      check("post_reset_do_b", do_b, 8'h00);

      // A writes, B reads one cycle later
      write_a(11'h123, 8'h5A);
      tick();
      idle();
      read_b(11'h123);
      tick();
      idle();
      check("cross_port_read", do_b, 8'h5A);

      // read-during-write across ports
      write_a(11'h010, 8'h11);
      tick();
      write_a(11'h010, 8'h22);
      read_b(11'h010);
      tick();
      idle();
      check("rdw_other_port", do_b, exp_rdw);
      read_b(11'h010);
      tick();
      idle();
      check("rdw_next_read", do_b, 8'h22);

      // read-during-write on the same port (A writes and reads 0x010)
      write_a(11'h010, 8'h33);
      tick();
      idle();
      check("rdw_same_port", do_a, exp_same);
      read_b(11'h010);
      tick();
      idle();
      check("rdw_same_port_after", do_b, 8'h33);

      // collision at top address, both ports also reading it
      write_a(11'h7FF, 8'h01);
      tick();
      write_a(11'h7FF, 8'hAA);
      ce_b = 1'b1; we_b = 1'b1; addr_b = 11'h7FF; di_b = 8'hBB;
      tick();
      idle();
      check("collision_rd_a", do_a, exp_col);
      check("collision_rd_b", do_b, exp_col);
      read_b(11'h7FF);
      tick();
      idle();
      check("collision_result", do_b, 8'hAA);

      // ce_b low: do_b holds while addr_b changes
      ce_b = 1'b0; addr_b = 11'h123;
      tick();
      addr_b = 11'h010;
      tick();
      check("ce_b_hold", do_b, 8'hAA);

      // oe_b low gates the output combinationally
      oe_b = 1'b0;
      #1;
      check("oe_b_gate", do_b, 8'h00);
      oe_b = 1'b1;
      #1;
      check("oe_b_restore", do_b, 8'hAA);

      // we_a without ce_a must not write
      ce_a = 1'b0; we_a = 1'b1; addr_a = 11'h123; di_a = 8'hEE;
      tick();
      idle();
      read_b(11'h123);
      tick();
      idle();
      check("ce_a_low_no_write", do_b, 8'h5A);

      // reset mid-operation: write attempted during reset is dropped,
      // enabled reads during reset keep outputs at 0
      write_a(11'h050, 8'h44);
      tick();
      idle();
      rst_n = 1'b0;
      #1;
      check("async_reset_do_b", do_b, 8'h00);
      write_a(11'h050, 8'h99);
      read_b(11'h050);
      tick();
      check("reset_read_blocked", do_b, 8'h00);
      idle();
      rst_n = 1'b1;
      read_b(11'h050);
      tick();
      idle();
      check("reset_write_blocked", do_b, 8'h44);

      // full sweep: write addr[7:0]^0x3C everywhere via A, read back via B
      for (int unsigned i = 0; i < (1 << aw); i++) begin
         sweep_d = 8'(i) ^ 8'h3C;
         write_a(aw'(i), sweep_d);
         tick();
      end
      idle();
      for (int unsigned i = 0; i < (1 << aw); i++) begin
         read_b(aw'(i));
         tick();
         sweep_d = 8'(i) ^ 8'h3C;
         check($sformatf("sweep_%03h", i), do_b, sweep_d);
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
